// File: rtl/dbg_slave_sysclk_bridge.sv
// System-clock half of the debug slave: synchronises the virtual-JTAG update strobes
// and queues each captured DR/IR update in a show-ahead command FIFO.
module dbg_slave_sysclk_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_is_dr,
    output logic [IR_W-1:0]               cmd_ir,
    output logic [DATA_W-1:0]             cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 1 + IR_W + DATA_W;

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync, fill;
    logic udr_d, uir_d, udr_armed, uir_armed;
    logic udr_out, uir_out, udr_rise, uir_rise;

    assign udr_out = udr_sync[SYNC_STAGES-1];
    assign uir_out = uir_sync[SYNC_STAGES-1];

    // A strobe already high when reset releases must fall once before it can
    // raise an event; 'fill' marks when the chain output reflects a real sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync  <= '0;
            uir_sync  <= '0;
            fill      <= '0;
            udr_d     <= 1'b0;
            uir_d     <= 1'b0;
            udr_armed <= 1'b0;
            uir_armed <= 1'b0;
        end else begin
            udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            udr_d     <= udr_out;
            uir_d     <= uir_out;
            udr_armed <= udr_armed | (fill[SYNC_STAGES-1] & ~udr_out);
            uir_armed <= uir_armed | (fill[SYNC_STAGES-1] & ~uir_out);
        end
    end

    assign udr_rise = udr_out & ~udr_d & udr_armed;
    assign uir_rise = uir_out & ~uir_d & uir_armed;

    logic            pend_valid;
    logic [IR_W-1:0] pend_ir;
    logic            push_pend, push_ir, push;
    logic [EW-1:0]   push_entry;

    // DR wins the write port; a colliding IR event waits one cycle in 'pend'.
    always_comb begin
        push_pend  = ~udr_rise & pend_valid;
        push_ir    = ~udr_rise & ~pend_valid & uir_rise;
        push       = udr_rise | push_pend | push_ir;
        push_entry = '0;
        if (udr_rise)
            push_entry = {1'b1, ir_in, sr};
        else if (push_pend)
            push_entry = {1'b0, (uir_rise ? ir_in : pend_ir), {DATA_W{1'b0}}};
        else if (push_ir)
            push_entry = {1'b0, ir_in, {DATA_W{1'b0}}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_valid <= 1'b0;
            pend_ir    <= '0;
        end else if (udr_rise & uir_rise) begin
            pend_valid <= 1'b1;
            pend_ir    <= ir_in;
        end else if (push_pend) begin
            pend_valid <= 1'b0;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          full, pop, wr_en, drop;
    logic [EW-1:0] head;

    assign full      = (level == LW'(FIFO_DEPTH));
    assign cmd_valid = (level != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign wr_en     = push & (~full | pop);
    assign drop      = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)
                level <= level + LW'(1);
            else if (pop && !wr_en)
                level <= level - LW'(1);
            overflow <= drop | (overflow & ~overflow_clr);
        end
    end

    // Head fields read as zero while empty so reset values hold without resetting mem.
    assign head = cmd_valid ? mem[rd_ptr] : '0;
    assign {cmd_is_dr, cmd_ir, cmd_data} = head;
    assign fifo_level = level;

endmodule

// File: tb/tb_dbg_slave_sysclk_bridge.sv
// Scoreboarded bench for dbg_slave_sysclk_bridge: strobe drivers push expected
// commands, a negedge monitor checks every accepted head against the queue.
module tb_dbg_slave_sysclk_bridge;
    localparam int DATA_W = 38;
    localparam int IR_W   = 2;
    localparam int DEPTH  = 4;
    localparam int EW     = 1 + IR_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              vs_udr, vs_uir;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              cmd_valid, cmd_ready, cmd_is_dr;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] cmd_data;
    logic [2:0]        fifo_level;
    logic              overflow, overflow_clr;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    bit rand_phase = 1'b0;

    logic       valid_e1, valid_e2, ovf_e2;
    logic [2:0] level_e2, level_e3;

    dbg_slave_sysclk_bridge #(
        .DATA_W(DATA_W), .IR_W(IR_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_dr(cmd_is_dr), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: handshake seen at negedge completes at the following posedge
    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected none", {cmd_is_dr, cmd_ir, cmd_data});
            end else begin
                check("head", 64'({cmd_is_dr, cmd_ir, cmd_data}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver: one strobe pulse; push edge is the 3rd posedge after vs goes high
    task automatic strobe(input bit do_udr, input bit do_uir, input logic [IR_W-1:0] ir,
                          input logic [DATA_W-1:0] d, input int hold, input bit rdy,
                          input bit clr, input bit expect_drop);
        if (do_udr && !expect_drop) exp_q.push_back({1'b1, ir, d});
        if (do_uir) exp_q.push_back({1'b0, ir, {DATA_W{1'b0}}});
        @(posedge clk); #2;
        ir_in = ir; sr = d; vs_udr = do_udr; vs_uir = do_uir;
        @(posedge clk); #2;
        @(posedge clk); #2;
        valid_e1 = cmd_valid;
        if (!rand_phase) cmd_ready = rdy;
        overflow_clr = clr;
        @(posedge clk); #2;
        valid_e2 = cmd_valid; level_e2 = fifo_level; ovf_e2 = overflow;
        if (!rand_phase) cmd_ready = 1'b0;
        overflow_clr = 1'b0;
        @(posedge clk); #2;
        level_e3 = fifo_level;
        repeat (hold) @(posedge clk);
        #2;
        vs_udr = 1'b0; vs_uir = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n = 0;
        cmd_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        @(posedge clk); #2;
        cmd_ready = 1'b0;
        check("drain_bound", 64'(n < 40), 64'(1));
        check("drain_level", 64'(fifo_level), 64'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] first_four[4];
        reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", 64'(cmd_valid), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_head", 64'({cmd_is_dr, cmd_ir, cmd_data}), 64'(0));
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #2;

        // latency and single event for a long level
        strobe(1, 0, 2'b01, 38'h2A_DEADBEEF, 6, 0, 0, 0);
        check("t1_valid_e1", 64'(valid_e1), 64'(0));
        check("t1_valid_e2", 64'(valid_e2), 64'(1));
        check("t1_level", 64'(fifo_level), 64'(1));
        check("t1_is_dr", 64'(cmd_is_dr), 64'(1));
        check("t1_ir", 64'(cmd_ir), 64'(2'b01));
        check("t1_data", 64'(cmd_data), 64'(38'h2A_DEADBEEF));
        drain();

        // simultaneous DR and IR
        d = {$urandom_range(0, 63), $urandom()};
        strobe(1, 1, 2'b10, d, 2, 0, 0, 0);
        check("t2_level_e2", 64'(level_e2), 64'(1));
        check("t2_level_e3", 64'(level_e3), 64'(2));
        drain();

        // fill then overflow
        for (int i = 0; i < 5; i++) begin
            d = {$urandom_range(0, 63), $urandom()};
            if (i < 4) first_four[i] = d;
            strobe(1, 0, 2'(i), d, 1, 0, 0, i == 4);
            check("t3_level", 64'(level_e2), 64'((i < 4) ? i + 1 : 4));
            check("t3_ovf", 64'(ovf_e2), 64'(i == 4));
        end
        check("t3_order_head", 64'(cmd_data), 64'(first_four[0]));

        // clear coincident with a drop loses, clear alone wins
        strobe(1, 0, 2'b11, 38'h1, 1, 0, 1, 1);
        check("t5_ovf_kept", 64'(ovf_e2), 64'(1));
        @(posedge clk); #2; overflow_clr = 1'b1;
        @(posedge clk); #2; overflow_clr = 1'b0;
        check("t5_ovf_cleared", 64'(overflow), 64'(0));

        // full with same-cycle pop
        strobe(1, 0, 2'b00, 38'h3F_12345678, 1, 1, 0, 0);
        check("t4_level", 64'(level_e2), 64'(4));
        check("t4_ovf", 64'(ovf_e2), 64'(0));
        drain();

        // async reset mid-cycle with entries queued and vs_udr held high
        for (int i = 0; i < 3; i++) strobe(1, 0, 2'(i), 38'(i + 7), 1, 0, 0, 0);
        @(posedge clk); #2; vs_udr = 1'b1;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_valid", 64'(cmd_valid), 64'(0));
        check("t6_level", 64'(fifo_level), 64'(0));
        check("t6_head", 64'({cmd_is_dr, cmd_ir, cmd_data}), 64'(0));
        repeat (2) @(posedge clk);
        #2; reset_n = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        check("t6_no_push_held", 64'(fifo_level), 64'(0));
        vs_udr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        strobe(1, 0, 2'b01, 38'h15_55555555, 1, 0, 0, 0);
        check("t6_repush", 64'(level_e2), 64'(1));
        drain();

        // randomized strobes with random consumer back-pressure
        rand_phase = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    int kind;
                    kind = $urandom_range(0, 2);
                    d = {$urandom_range(0, 63), $urandom()};
                    strobe(kind != 1, kind != 0, 2'($urandom_range(0, 3)), d,
                           $urandom_range(0, 3), 0, 0, 0);
                end
                rand_phase = 1'b0;
            end
            begin
                while (rand_phase) begin
                    @(posedge clk); #2;
                    cmd_ready = (exp_q.size() >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("final_ovf", 64'(overflow), 64'(0));
        check("final_queue", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
